// File: rtl/nios_fprint_button_debounce_if.sv
// Button pin bundle between the board pads and the debouncer.
// master drives the raw pins; slave returns clean levels and strobes.
interface nios_fprint_button_debounce_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] btn_raw;
    logic [WIDTH-1:0] btn_out;
    logic [WIDTH-1:0] press_pulse;
    logic [WIDTH-1:0] release_pulse;

    modport master (
        output btn_raw,
        input  btn_out,
        input  press_pulse,
        input  release_pulse
    );

    modport slave (
        input  btn_raw,
        output btn_out,
        output press_pulse,
        output release_pulse
    );
endinterface

// File: rtl/nios_fprint_button_debounce.sv
// Per-bit synchroniser, stability counter and press/release strobes
// feeding the Nios button PIO (1 = pressed on every output).
module nios_fprint_button_debounce #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int INVERT          = 1
) (
    input logic                           clk,
    input logic                           reset_n,
    nios_fprint_button_debounce_if.slave  bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [WIDTH-1:0] IDLE_RAW =
        (INVERT != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_stab;
    logic [WIDTH-1:0] r_press;
    logic [WIDTH-1:0] r_release;
    logic [CNT_W-1:0] r_cnt [WIDTH];
    logic [WIDTH-1:0] w_lvl;

    assign w_lvl = r_s2 ^ IDLE_RAW;

    // Reset loads the idle pin level so nothing looks pressed on exit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1      <= IDLE_RAW;
            r_s2      <= IDLE_RAW;
            r_stab    <= '0;
            r_press   <= '0;
            r_release <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1 <= bus.btn_raw;
            r_s2 <= r_s1;
            for (int i = 0; i < WIDTH; i++) begin
                r_press[i]   <= 1'b0;
                r_release[i] <= 1'b0;
                if (w_lvl[i] == r_stab[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_stab[i]    <= w_lvl[i];
                    r_cnt[i]     <= '0;
                    r_press[i]   <= w_lvl[i];
                    r_release[i] <= ~w_lvl[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    assign bus.btn_out       = r_stab;
    assign bus.press_pulse   = r_press;
    assign bus.release_pulse = r_release;
endmodule

// File: tb/tb_nios_fprint_button_debounce.sv
// Directed and randomised checks of the button debouncer against
// a sample-window model of the acceptance rule.
module tb_nios_fprint_button_debounce;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    nios_fprint_button_debounce_if #(.WIDTH(2)) ifa ();
    nios_fprint_button_debounce_if #(.WIDTH(2)) ifb ();

    nios_fprint_button_debounce #(
        .WIDTH(2), .DEBOUNCE_CYCLES(4), .INVERT(1)
    ) dut_a (
        .clk(clk), .reset_n(rst_n), .bus(ifa)
    );

    nios_fprint_button_debounce #(
        .WIDTH(2), .DEBOUNCE_CYCLES(1), .INVERT(0)
    ) dut_b (
        .clk(clk), .reset_n(rst_n), .bus(ifb)
    );

    // Model: a level is accepted once the last d synchronised samples
    // all differ from the accepted level.
    typedef struct packed {
        logic [1:0]       p1;
        logic [1:0]       p2;
        logic [1:0]       stab;
        logic [1:0]       pr;
        logic [1:0]       rl;
        logic [1:0][63:0] h;
    } mst_t;

    mst_t ma = '0;
    mst_t mb = '0;

    function automatic mst_t mdl(mst_t s, int d, bit inv,
                                 logic rst, logic [1:0] raw);
        mst_t        n;
        logic [1:0]  idle;
        logic [1:0]  lvl;
        logic [63:0] mask;
        logic [63:0] win;
        n    = s;
        idle = inv ? 2'b11 : 2'b00;
        mask = (64'd1 << d) - 64'd1;
        if (!rst) begin
            n.p1   = idle;
            n.p2   = idle;
            n.stab = 2'b00;
            n.pr   = 2'b00;
            n.rl   = 2'b00;
            n.h    = '0;
            return n;
        end
        lvl  = s.p2 ^ idle;
        n.pr = 2'b00;
        n.rl = 2'b00;
        for (int i = 0; i < 2; i++) begin
            n.h[i] = {s.h[i][62:0], lvl[i]};
            win    = n.h[i] & mask;
            if (win == (s.stab[i] ? 64'd0 : mask)) begin
                n.stab[i] = lvl[i];
                n.pr[i]   = lvl[i];
                n.rl[i]   = ~lvl[i];
            end
        end
        n.p2 = s.p1;
        n.p1 = raw;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [1:0] obs,
                       input logic [1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [1:0] ra, input logic [1:0] rb,
                        input logic rs);
        @(negedge clk);
        ifa.btn_raw = ra;
        ifb.btn_raw = rb;
        rst_n       = rs;
        @(posedge clk);
        ma = mdl(ma, 4, 1'b1, rs, ra);
        mb = mdl(mb, 1, 1'b0, rs, rb);
        #1;
        chk("a_out", ifa.btn_out, ma.stab);
        chk("a_press", ifa.press_pulse, ma.pr);
        chk("a_release", ifa.release_pulse, ma.rl);
        chk("b_out", ifb.btn_out, mb.stab);
        chk("b_press", ifb.press_pulse, mb.pr);
        chk("b_release", ifb.release_pulse, mb.rl);
    endtask

    initial begin
        logic [1:0] ra;
        logic [1:0] rb;
        logic       rs;
        int         hold;
        rst_n       = 1'b0;
        ifa.btn_raw = 2'b11;
        ifb.btn_raw = 2'b00;

        // reset state
        repeat (3) step(2'b11, 2'b00, 1'b0);
        chk("rst_out", ifa.btn_out, 2'b00);
        repeat (20) step(2'b11, 2'b00, 1'b1);
        chk("idle_out", ifa.btn_out, 2'b00);
        chk("idle_press", ifa.press_pulse, 2'b00);

        // clean press then release on bit 0
        repeat (5) step(2'b10, 2'b00, 1'b1);
        chk("press_early", ifa.btn_out, 2'b00);
        step(2'b10, 2'b00, 1'b1);
        chk("press_out", ifa.btn_out, 2'b01);
        chk("press_pulse", ifa.press_pulse, 2'b01);
        step(2'b10, 2'b00, 1'b1);
        chk("press_one", ifa.press_pulse, 2'b00);
        repeat (5) step(2'b11, 2'b00, 1'b1);
        chk("rel_early", ifa.btn_out, 2'b01);
        step(2'b11, 2'b00, 1'b1);
        chk("rel_out", ifa.btn_out, 2'b00);
        chk("rel_pulse", ifa.release_pulse, 2'b01);
        repeat (4) step(2'b11, 2'b00, 1'b1);

        // bounce on bit 1, then a held press
        foreach (ifa.btn_raw[k]) begin end
        step(2'b01, 2'b00, 1'b1);
        step(2'b01, 2'b00, 1'b1);
        step(2'b01, 2'b00, 1'b1);
        step(2'b11, 2'b00, 1'b1);
        step(2'b01, 2'b00, 1'b1);
        step(2'b01, 2'b00, 1'b1);
        step(2'b01, 2'b00, 1'b1);
        step(2'b11, 2'b00, 1'b1);
        chk("bounce_out", ifa.btn_out, 2'b00);
        repeat (5) step(2'b01, 2'b00, 1'b1);
        chk("bounce_wait", ifa.btn_out, 2'b00);
        step(2'b01, 2'b00, 1'b1);
        chk("bounce_acc", ifa.btn_out, 2'b10);
        chk("bounce_pulse", ifa.press_pulse, 2'b10);
        repeat (8) step(2'b11, 2'b00, 1'b1);
        chk("bounce_rel", ifa.btn_out, 2'b00);

        // both buttons on the same edge
        repeat (5) step(2'b00, 2'b00, 1'b1);
        chk("both_wait", ifa.btn_out, 2'b00);
        step(2'b00, 2'b00, 1'b1);
        chk("both_out", ifa.btn_out, 2'b11);
        chk("both_pulse", ifa.press_pulse, 2'b11);
        step(2'b00, 2'b00, 1'b1);
        chk("both_one", ifa.press_pulse, 2'b00);
        repeat (8) step(2'b11, 2'b00, 1'b1);

        // reset part way through a count, pin held low
        repeat (3) step(2'b10, 2'b00, 1'b1);
        repeat (2) step(2'b10, 2'b00, 1'b0);
        chk("midrst_out", ifa.btn_out, 2'b00);
        repeat (5) step(2'b10, 2'b00, 1'b1);
        chk("midrst_wait", ifa.btn_out, 2'b00);
        step(2'b10, 2'b00, 1'b1);
        chk("midrst_acc", ifa.btn_out, 2'b01);
        chk("midrst_pulse", ifa.press_pulse, 2'b01);
        repeat (8) step(2'b11, 2'b00, 1'b1);

        // single-cycle debounce, no inversion
        step(2'b11, 2'b10, 1'b1);
        step(2'b11, 2'b10, 1'b1);
        chk("pass_e1", ifb.btn_out, 2'b00);
        step(2'b11, 2'b10, 1'b1);
        chk("pass_out", ifb.btn_out, 2'b10);
        chk("pass_pulse", ifb.press_pulse, 2'b10);
        step(2'b11, 2'b10, 1'b1);
        chk("pass_one", ifb.press_pulse, 2'b00);
        repeat (4) step(2'b11, 2'b00, 1'b1);

        // random held levels with occasional resets
        for (int k = 0; k < 400; k++) begin
            hold = $urandom_range(1, 9);
            ra   = 2'($urandom);
            rs   = ($urandom_range(0, 39) != 0);
            repeat (hold) begin
                rb = 2'($urandom);
                step(ra, rb, rs);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/nios_fprint_button_debounce.md
# nios_fprint_button_debounce

Debounces and synchronises the raw push-button pins of the fprint board before they reach the Nios button PIO. Each bit goes through a two-flop synchroniser and a per-bit stability counter. Each bit is optionally inverted so that 1 means pressed. The clean level drives the PIO `in_port`, whose rising-edge capture then fires once per physical press. One-cycle press and release strobes are also provided for hardware consumers that do not go through software.

## Interface
- `WIDTH`, 2, number of buttons; matches the PIO `in_port` width.
- `DEBOUNCE_CYCLES`, 50000, consecutive stable cycles required before a level change is accepted (1 ms at 50 MHz); legal range ≥1.
- `INVERT`, 1, 1 means the raw pins are active-low (idle 1) and outputs are inverted to active-high; 0 means no inversion.
- Counter width `CNT_W` = ceil(log2(DEBOUNCE_CYCLES+1)), derived locally, not overridable.

- `clk`  in  1  system clock; one clock domain, all logic on the rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `btn_raw`  in  WIDTH  asynchronous board pins.
- `btn_out`  out  WIDTH  debounced level, 1 = pressed; connects to the PIO `in_port`.
- `press_pulse`  out  WIDTH  one-cycle strobe when a bit's `btn_out` goes 0→1.
- `release_pulse`  out  WIDTH  one-cycle strobe when a bit's `btn_out` goes 1→0.

## Operation
- Define `idle_raw` = INVERT ? all-ones : all-zeros, and `lvl` = s2 XOR {WIDTH{INVERT}}.
- Synchroniser: `s1 <= btn_raw`, then `s2 <= s1`. Reset loads `idle_raw` into both, so no false press is seen out of reset.
- Each bit `i` is independent and has a counter `cnt[i]` and a stable state `stab[i]` (= `btn_out[i]`).
- If `lvl[i] == stab[i]`: `cnt[i] <= 0`. Any bounce back to the accepted level therefore restarts the count.
- If `lvl[i] != stab[i]` and `cnt[i] == DEBOUNCE_CYCLES-1`: `stab[i] <= lvl[i]` and `cnt[i] <= 0`. On the same edge, pulse `press_pulse[i]` if the new value is 1, or `release_pulse[i]` if it is 0.
- If `lvl[i] != stab[i]` and `cnt[i]` is below that value: `cnt[i] <= cnt[i]+1`.
- Pulses are registered and are 0 on every cycle without an accepted change. Press and release can never both be 1 for the same bit.
- Different bits may toggle on the same edge; each bit asserts its own pulse.
- The counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- With DEBOUNCE_CYCLES=1 the block acts as a pure two-flop synchroniser plus pulse generator.
- Reset (`reset_n`=0 at a rising edge), including mid-count:
  - `s1`, `s2` ← `idle_raw`
  - `cnt` ← 0
  - `btn_out` ← 0
  - `press_pulse` ← 0
  - `release_pulse` ← 0
  - A partially counted transition is discarded.
  - A button held down through reset is reported as a fresh press once it has been stable for the full DEBOUNCE_CYCLES after reset release.

## Timing
- All outputs are registers; there are no combinational paths from input to output.
- Latency: suppose `btn_raw[i]` changes before edge E0 and then stays stable.
  - `s2` updates at E1.
  - The first count increment happens at E2.
  - `btn_out[i]` and the matching pulse update at edge E(DEBOUNCE_CYCLES+1). They are visible DEBOUNCE_CYCLES+2 cycles after the pin change.
- A glitch is rejected if the new level persists for fewer than DEBOUNCE_CYCLES consecutive `s2` samples.
- Pulse width is exactly 1 cycle.
- The minimum spacing between two pulses on the same bit is DEBOUNCE_CYCLES cycles.
- There is no handshake and no backpressure; downstream must sample every cycle. The PIO's registered edge detect meets this requirement.

## Test plan
Use DEBOUNCE_CYCLES=4, INVERT=1 and WIDTH=2 for all scenarios.

1. **Reset state:** hold `reset_n`=0 for 3 cycles with `btn_raw`=2'b11, then release → `btn_out`=0, both pulse outputs 0, and they stay 0 for 20 cycles.
2. **Clean press/release:**
   - Drive `btn_raw[0]`=0 before edge E0 → `btn_out[0]`=1 after E5, with `press_pulse`=2'b01 for that single cycle only.
   - Later drive `btn_raw[0]`=1 → after 6 edges `btn_out[0]`=0 and `release_pulse`=2'b01 for one cycle.
3. **Bounce rejection:** drive the pattern 0,0,0,1,0,0,0,1 cycle-by-cycle on `btn_raw[1]` → no change on `btn_out[1]` and no pulses. Then hold it at 0 → press accepted 6 edges after the last 1→0 change.
4. **Simultaneous buttons:** drive `btn_raw` 11→00 on the same cycle → `btn_out` goes 00→11 on one edge and `press_pulse`=2'b11 for one cycle.
5. **Reset mid-count:** drive `btn_raw[0]`=0, then assert `reset_n` on the 4th cycle after the change, and keep the pin low → `btn_out[0]`=0 through reset. After release, press is accepted at edge E5 counted from the first edge with `reset_n`=1.
6. **Pass-through mode:** with DEBOUNCE_CYCLES=1 and INVERT=0, drive `btn_raw`=2'b10 → `btn_out`=2'b10 after the 2nd edge and `press_pulse`=2'b10 for one cycle.
